// File: rtl/load_store_unit_if.sv
// Core-side request/response and RAM-side word bus of the load/store unit.
// slave = the load/store unit itself; master = the core plus data RAM around it.
interface load_store_unit_if;
  // Core handshake: a request is taken on a rising edge where req && ready.
  // ready is high only while idle, so the request fields only matter on that
  // edge; done is a one-cycle pulse, and fault and rdata are meaningful with it.
  logic        req;
  logic        store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic        fault;
  logic [31:0] rdata;

  // RAM bus: word index, 1-cycle synchronous read, write on the same edge.
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_w;
  logic [31:0] mem_read_data;

  modport slave (
    input  req, store, funct3, addr, wdata, mem_read_data,
    output ready, done, fault, rdata, mem_address, mem_write_data, mem_w
  );

  modport master (
    output req, store, funct3, addr, wdata, mem_read_data,
    input  ready, done, fault, rdata, mem_address, mem_write_data, mem_w
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I byte-addressed loads/stores onto a word-addressed synchronous RAM.
// Sub-word stores are read-modify-write; bad requests fault without RAM access.
module load_store_unit #(
  parameter int unsigned MEM_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.slave  bus,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_CAP  = 2'd2,
    S_WR   = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_store;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr_lo;
  logic [15:0] r_wdata_lo;
  logic        r_done;
  logic        r_fault;
  logic [31:0] r_rdata;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_mem_w;

  logic        w_accept;
  logic        w_illegal;
  logic        w_misalign;
  logic        w_range;
  logic        w_fault;
  logic        w_is_sw;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_val;
  logic [31:0] w_merged;

  assign w_accept = bus.req && (r_state == S_IDLE);
  assign w_is_sw  = bus.store && (bus.funct3 == 3'b010);

  // Request screening on the raw inputs; only used on the accept edge.
  always_comb begin
    w_illegal  = 1'b0;
    w_misalign = 1'b0;
    w_range    = 1'b0;
    if (bus.store)
      w_illegal = bus.funct3[2] || (bus.funct3[1:0] == 2'b11);
    else
      w_illegal = (bus.funct3[1:0] == 2'b11) || (bus.funct3 == 3'b110);
    if (bus.funct3[1:0] == 2'b01)
      w_misalign = bus.addr[0];
    else if (bus.funct3[1:0] == 2'b10)
      w_misalign = (bus.addr[1:0] != 2'b00);
    w_range = ({2'b00, bus.addr[31:2]} >= 32'(MEM_DEPTH));
  end

  assign w_fault = w_illegal || w_misalign || w_range;

  // Lane selection from the word the RAM returns during CAP.
  always_comb begin
    w_byte     = bus.mem_read_data[{r_addr_lo, 3'b000} +: 8];
    w_half     = r_addr_lo[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];
    w_load_val = bus.mem_read_data;
    case (r_funct3)
      3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_val = {24'h0, w_byte};
      3'b101:  w_load_val = {16'h0, w_half};
      default: w_load_val = bus.mem_read_data;
    endcase
  end

  always_comb begin
    w_merged = bus.mem_read_data;
    if (r_funct3[1:0] == 2'b00)
      w_merged[{r_addr_lo, 3'b000} +: 8] = r_wdata_lo[7:0];
    else if (r_addr_lo[1])
      w_merged[31:16] = r_wdata_lo;
    else
      w_merged[15:0] = r_wdata_lo;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_store     <= 1'b0;
      r_funct3    <= 3'b000;
      r_addr_lo   <= 2'b00;
      r_wdata_lo  <= 16'h0;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
      r_rdata     <= 32'h0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
      r_mem_w     <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_fault <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_store    <= bus.store;
            r_funct3   <= bus.funct3;
            r_addr_lo  <= bus.addr[1:0];
            r_wdata_lo <= bus.wdata[15:0];
            if (w_fault) begin
              r_done  <= 1'b1;
              r_fault <= 1'b1;
              r_rdata <= 32'h0;
            end else begin
              r_mem_addr <= {2'b00, bus.addr[31:2]};
              if (w_is_sw) begin
                // Full-word store needs no read: write on the next edge.
                r_mem_wdata <= bus.wdata;
                r_mem_w     <= 1'b1;
                r_state     <= S_WR;
              end else begin
                r_state <= S_RD;
              end
            end
          end
        end
        S_RD: begin
          r_state <= S_CAP;
        end
        S_CAP: begin
          if (r_store) begin
            r_mem_wdata <= w_merged;
            r_mem_w     <= 1'b1;
            r_state     <= S_WR;
          end else begin
            r_rdata    <= w_load_val;
            r_done     <= 1'b1;
            r_mem_addr <= 32'h0;
            r_state    <= S_IDLE;
          end
        end
        S_WR: begin
          r_mem_w     <= 1'b0;
          r_mem_wdata <= 32'h0;
          r_mem_addr  <= 32'h0;
          r_done      <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready          = (r_state == S_IDLE);
  assign bus.done           = r_done;
  assign bus.fault          = r_fault;
  assign bus.rdata          = r_rdata;
  assign bus.mem_address    = r_mem_addr;
  assign bus.mem_write_data = r_mem_wdata;
  // Gate with rst so a write in flight is cut off without waiting for an edge.
  assign bus.mem_w          = r_mem_w && !rst;
  assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random traffic against a
// byte-array memory model with a behavioural RAM on the DUT's word bus.
module tb_load_store_unit;
  localparam int DEPTH = 1024;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: read-old on the write edge, 1-cycle read latency.
  logic [31:0] ram [0:DEPTH-1] = '{default: 32'h0};
  always @(posedge clk) begin
    if (bus.mem_w) ram[bus.mem_address[9:0]] <= bus.mem_write_data;
    bus.mem_read_data <= ram[bus.mem_address[9:0]];
  end

  // Reference model: plain byte-addressed memory.
  logic [7:0]  ref_mem [0:4*DEPTH-1] = '{default: 8'h0};
  logic [31:0] ref_rdata = 32'h0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit ref_fault(input bit st, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    if (st) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    if (!legal) return 1'b1;
    if ((a % size_of(f3)) != 0) return 1'b1;
    if ((a / 4) >= DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    int     n = size_of(f3);
    longint v = 0;
    for (int i = 0; i < n; i++) v = v | (longint'(ref_mem[a + i]) << (8 * i));
    if (!f3[2] && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_mem[4*idx+3], ref_mem[4*idx+2], ref_mem[4*idx+1], ref_mem[4*idx]};
  endfunction

  // Called at a falling edge with the DUT idle; returns at the falling edge of the Done cycle.
  task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input string tag);
    bit          exp_f;
    int          exp_lat;
    int          lat;
    int          wcount;
    logic [31:0] exp_rd;
    exp_f = ref_fault(st, f3, a);
    if (exp_f)                    exp_lat = 1;
    else if (!st)                 exp_lat = 3;
    else if (f3 == 3'd2)          exp_lat = 2;
    else                          exp_lat = 4;
    if (exp_f)    exp_rd = 32'h0;
    else if (!st) exp_rd = ref_load(f3, a);
    else          exp_rd = ref_rdata;

    check({tag, "_ready"}, 32'(bus.ready), 32'd1);
    bus.req = 1'b1; bus.store = st; bus.funct3 = f3; bus.addr = a; bus.wdata = wd;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    bus.store = 1'($urandom_range(0, 1)); bus.funct3 = 3'($urandom_range(0, 7));
    bus.addr = $urandom; bus.wdata = $urandom;
    lat = 1;
    wcount = 0;
    while (!bus.done && lat < 8) begin
      if (bus.mem_w) wcount++;
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_fault"}, 32'(bus.fault), 32'(exp_f));
    check({tag, "_rdata"}, bus.rdata, exp_rd);
    check({tag, "_wcount"}, 32'(wcount), (st && !exp_f) ? 32'd1 : 32'd0);
    check({tag, "_idle_bus"}, bus.mem_address | bus.mem_write_data | 32'(bus.mem_w), 32'h0);

    if (!exp_f && st)
      for (int i = 0; i < size_of(f3); i++) ref_mem[a + i] = wd[8*i +: 8];
    ref_rdata = exp_rd;
    if (!exp_f && st) check({tag, "_ram"}, ram[a / 4], ref_word(int'(a / 4)));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bit          st;
    logic [2:0]  f3;
    logic [31:0] a;
    int          r;

    rst = 1'b1;
    bus.req = 1'b0; bus.store = 1'b0; bus.funct3 = 3'd0; bus.addr = 32'h0; bus.wdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_fault", 32'(bus.fault), 32'd0);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_bus", bus.mem_address | bus.mem_write_data | 32'(bus.mem_w), 32'h0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Loads from RAM[5] = 0x80FF_7F01
    run_op(1, 3'd2, 32'h14, 32'h80FF_7F01, "sw_init");
    run_op(0, 3'd0, 32'h14, 32'h0, "lb14");  check("lb14_k", bus.rdata, 32'h0000_0001);
    run_op(0, 3'd0, 32'h17, 32'h0, "lb17");  check("lb17_k", bus.rdata, 32'hFFFF_FF80);
    run_op(0, 3'd4, 32'h17, 32'h0, "lbu17"); check("lbu17_k", bus.rdata, 32'h0000_0080);
    run_op(0, 3'd1, 32'h16, 32'h0, "lh16");  check("lh16_k", bus.rdata, 32'hFFFF_80FF);
    run_op(0, 3'd5, 32'h16, 32'h0, "lhu16"); check("lhu16_k", bus.rdata, 32'h0000_80FF);
    run_op(0, 3'd2, 32'h14, 32'h0, "lw14");  check("lw14_k", bus.rdata, 32'h80FF_7F01);

    // Sub-word stores into RAM[5] = 0x1122_3344
    run_op(1, 3'd2, 32'h14, 32'h1122_3344, "sw5");
    run_op(1, 3'd0, 32'h15, 32'h0000_00AB, "sb15"); check("sb15_k", ram[5], 32'h1122_AB44);
    run_op(1, 3'd1, 32'h16, 32'h0000_CDEF, "sh16"); check("sh16_k", ram[5], 32'hCDEF_AB44);
    run_op(1, 3'd2, 32'h14, 32'hDEAD_BEEF, "sw14"); check("sw14_k", ram[5], 32'hDEAD_BEEF);

    // Faults
    run_op(0, 3'd2, 32'h16, 32'h0, "f_lw16");
    run_op(1, 3'd1, 32'h15, 32'h0, "f_sh15");
    run_op(0, 3'd3, 32'h14, 32'h0, "f_f3_3");
    run_op(1, 3'd4, 32'h14, 32'h0, "f_st_f3_4");
    run_op(0, 3'd2, 32'h1000, 32'h0, "f_range"); check("f_range_k", bus.fault, 1'b1);

    // Back-to-back: load issued on the store's Done cycle
    run_op(1, 3'd2, 32'h20, 32'h1234_5678, "b2b_sw");
    run_op(0, 3'd2, 32'h20, 32'h0, "b2b_lw"); check("b2b_lw_k", bus.rdata, 32'h1234_5678);

    // Reset during the write phase of an SB
    bus.req = 1'b1; bus.store = 1'b1; bus.funct3 = 3'd0; bus.addr = 32'h15; bus.wdata = 32'hEE;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rstwr_memw_before", 32'(bus.mem_w), 32'd1);
    rst = 1'b1;
    #1;
    check("rstwr_memw", 32'(bus.mem_w), 32'd0);
    check("rstwr_state", 32'(dbg_state), 32'd0);
    check("rstwr_done", 32'(bus.done), 32'd0);
    check("rstwr_rdata", bus.rdata, 32'h0);
    check("rstwr_bus", bus.mem_address | bus.mem_write_data, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ref_rdata = 32'h0;
    check("rstwr_ram", ram[5], ref_word(5));
    r = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.done) r++;
      @(negedge clk);
    end
    check("rstwr_no_done", 32'(r), 32'd0);
    run_op(0, 3'd2, 32'h14, 32'h0, "post_rst"); check("post_rst_k", bus.rdata, 32'hDEAD_BEEF);

    // Random traffic
    for (int n = 0; n < 200; n++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      r  = $urandom_range(0, 9);
      if (r == 0)      a = 32'h1000 + 32'($urandom_range(0, 255));
      else if (r == 1) a = 32'hFFC + 32'($urandom_range(0, 3));
      else             a = 32'($urandom_range(0, 127));
      run_op(st, f3, a, $urandom, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
